// File: rtl/clkswitch_pkg.sv
// Shared types and encodings for the clock-switch controller.
package clkswitch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SWITCH = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/clk_alive_monitor.sv
// Heartbeat liveness monitor: 2-flop synchroniser, edge detect, saturating timeout.
module clk_alive_monitor
    import clkswitch_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_hb,
    output logic o_alive
);

    localparam int unsigned          CNT_W   = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(TIMEOUT);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic [CNT_W-1:0] r_cnt;
    logic             r_alive;
    logic             w_edge;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_edge  = r_sync2 ^ r_sync3;
    assign o_alive = r_alive;

    // Clear on any heartbeat edge, otherwise count up and hold at TIMEOUT.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_edge) begin
            w_cnt_nxt = '0;
        end else if (r_cnt < CNT_MAX) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // Synchroniser chain, counter and registered liveness flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_cnt   <= '0;
            r_alive <= 1'b1;
        end else begin
            r_sync1 <= i_hb;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_cnt   <= w_cnt_nxt;
            r_alive <= (w_cnt_nxt < CNT_MAX);
        end
    end

endmodule

// File: rtl/clkswitch_ctrl.sv
// Clock-source select controller with request handshake, settle delay and failover.
module clkswitch_ctrl
    import clkswitch_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned SETTLE  = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_hb_a,
    input  logic       i_hb_b,
    input  logic       i_req_valid,
    input  logic       i_req_sel,
    output logic       o_req_ready,
    output logic       o_sel,
    output logic       o_done,
    output logic       o_err,
    output logic       o_failover,
    output logic [1:0] o_alive
);

    localparam int unsigned      SET_W    = cnt_width(SETTLE - 1);
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sel;
    logic             w_sel_nxt;
    logic             r_target;
    logic             w_target_nxt;
    logic [SET_W-1:0] r_cnt;
    logic [SET_W-1:0] w_cnt_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             r_failover;
    logic             w_failover_nxt;
    logic             r_ready;
    logic             w_ready_nxt;
    logic [1:0]       w_alive;
    logic             w_cur_alive;
    logic             w_oth_alive;

    clk_alive_monitor #(.TIMEOUT(TIMEOUT)) u_mon_a (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_hb    (i_hb_a),
        .o_alive (w_alive[SRC_A])
    );

    clk_alive_monitor #(.TIMEOUT(TIMEOUT)) u_mon_b (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_hb    (i_hb_b),
        .o_alive (w_alive[SRC_B])
    );

    assign w_cur_alive = w_alive[r_sel];
    assign w_oth_alive = w_alive[~r_sel];

    assign o_req_ready = r_ready;
    assign o_sel       = r_sel;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_failover  = r_failover;
    assign o_alive     = w_alive;

    // Next-state and next-output decode; a pending request beats failover.
    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_target_nxt   = r_target;
        w_cnt_nxt      = r_cnt;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_failover_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    w_target_nxt = i_req_sel;
                    w_state_nxt  = ST_CHECK;
                end else if (!w_cur_alive && w_oth_alive) begin
                    w_target_nxt   = ~r_sel;
                    w_failover_nxt = 1'b1;
                    w_state_nxt    = ST_SWITCH;
                end
            end
            ST_CHECK: begin
                if (r_target == r_sel) begin
                    w_state_nxt = ST_DONE;
                end else if (w_alive[r_target]) begin
                    w_state_nxt = ST_SWITCH;
                end else begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SWITCH: begin
                w_sel_nxt   = r_target;
                w_cnt_nxt   = SET_LOAD;
                w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - SET_W'(1);
                end
            end
            ST_DONE: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    // State and registered outputs; reset forces source A immediately.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_sel      <= SRC_A;
            r_target   <= SRC_A;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_failover <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_target   <= w_target_nxt;
            r_cnt      <= w_cnt_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_failover <= w_failover_nxt;
            r_ready    <= w_ready_nxt;
        end
    end

endmodule

// File: tb/tb_clkswitch_ctrl.sv
// Scoreboard bench for clkswitch_ctrl: handshakes, settle latency, errors, failover, reset.
module tb_clkswitch_ctrl;

    localparam int unsigned TO = 16;
    localparam int unsigned ST = 4;

    localparam logic [2:0] K_DONE = 3'b001;
    localparam logic [2:0] K_ERR  = 3'b010;
    localparam logic [2:0] K_FO   = 3'b100;

    typedef struct {
        logic [2:0] kind;
        int         lo;
        int         hi;
        logic       sel;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       hb_a;
    logic       hb_b;
    logic       req_valid;
    logic       req_sel;
    logic       req_ready;
    logic       sel;
    logic       done;
    logic       err;
    logic       failover;
    logic [1:0] alive;

    logic       hb_en_a;
    logic       hb_en_b;
    int         hb_div = 0;
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];
    exp_t       mon_e;
    logic [2:0] mon_obs;

    clkswitch_ctrl #(.TIMEOUT(TO), .SETTLE(ST)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_hb_a      (hb_a),
        .i_hb_b      (hb_b),
        .i_req_valid (req_valid),
        .i_req_sel   (req_sel),
        .o_req_ready (req_ready),
        .o_sel       (sel),
        .o_done      (done),
        .o_err       (err),
        .o_failover  (failover),
        .o_alive     (alive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Heartbeats toggle every 4 cycles while enabled.
    always @(posedge clk) begin
        #2;
        hb_div = hb_div + 1;
        if (hb_div % 4 == 0) begin
            if (hb_en_a) hb_a = ~hb_a;
            if (hb_en_b) hb_b = ~hb_b;
        end
    end

    // Scoreboard: every pulse must match the oldest expectation in kind, cycle window and select.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0 && sb[0].hi < cyc) begin
            checks++;
            errors++;
            $display("FAIL sb_missing kind=%b due_by=%0d now=%0d", sb[0].kind, sb[0].hi, cyc);
            mon_e = sb.pop_front();
        end
        if ((done | err | failover) === 1'b1) begin
            mon_obs = {failover, err, done};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got=%b at cyc=%0d sel=%b", mon_obs, cyc, sel);
            end else begin
                mon_e = sb.pop_front();
                if (mon_obs !== mon_e.kind || cyc < mon_e.lo || cyc > mon_e.hi || sel !== mon_e.sel) begin
                    errors++;
                    $display("FAIL sb_event got kind=%b cyc=%0d sel=%b, exp kind=%b cyc=[%0d,%0d] sel=%b",
                             mon_obs, cyc, sel, mon_e.kind, mon_e.lo, mon_e.hi, mon_e.sel);
                end
                if (mon_e.kind == K_FO && mon_obs == K_FO)
                    sb.push_back('{K_DONE, cyc + ST + 2, cyc + ST + 2, ~mon_e.sel});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one request; expected pulse lands lat cycles after the handshake edge.
    task automatic do_req(input logic s, input logic [2:0] kind, input int lat,
                          input logic exp_sel, output int hs);
        int w;
        w = 0;
        while (req_ready !== 1'b1 && w < 50) begin
            tick(1);
            w++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_wait got=%b exp=1", req_ready);
        end
        req_valid = 1'b1;
        req_sel   = s;
        hs        = cyc + 1;
        sb.push_back('{kind, hs + lat, hs + lat, exp_sel});
        tick(1);
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_alive(input logic [1:0] want);
        int n;
        n = 0;
        while (alive !== want && n < 40) begin
            tick(1);
            n++;
        end
        checks++;
        if (alive !== want) begin
            errors++;
            $display("FAIL alive_recover got=%b exp=%b", alive, want);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        hb_a      = 1'b0;
        hb_b      = 1'b0;
        hb_en_a   = 1'b1;
        hb_en_b   = 1'b1;
        req_valid = 1'b0;
        req_sel   = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        checks++;
        if ({req_ready, sel, done, err, failover} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=10000", {req_ready, sel, done, err, failover});
        end
        checks++;
        if (alive !== 2'b11) begin
            errors++;
            $display("FAIL reset_alive got=%b exp=11", alive);
        end
    endtask

    task automatic test_switch();
        int hs;
        do_req(1'b1, K_DONE, ST + 3, 1'b1, hs);
        tick(1);
        checks++;
        if (sel !== 1'b0) begin
            errors++;
            $display("FAIL sel_before_switch got=%b exp=0", sel);
        end
        tick(1);
        checks++;
        if (sel !== 1'b1) begin
            errors++;
            $display("FAIL sel_at_switch got=%b exp=1", sel);
        end
        // Back-to-back request returns to A as soon as ready comes back.
        do_req(1'b0, K_DONE, ST + 3, 1'b0, hs);
        wait_drain(ST + 10);
        checks++;
        if (sel !== 1'b0) begin
            errors++;
            $display("FAIL sel_back_to_a got=%b exp=0", sel);
        end
    endtask

    task automatic test_same_sel();
        int   hs;
        logic bad;
        bad = 1'b0;
        do_req(1'b0, K_DONE, 2, 1'b0, hs);
        repeat (4) begin
            if (sel !== 1'b0) bad = 1'b1;
            tick(1);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL same_sel_stable got=changed exp=0");
        end
        wait_drain(5);
    endtask

    task automatic test_dead_target();
        int hs;
        hb_en_b = 1'b0;
        tick(TO + 8);
        checks++;
        if (alive !== 2'b01) begin
            errors++;
            $display("FAIL b_dead_alive got=%b exp=01", alive);
        end
        do_req(1'b1, K_ERR, 1, 1'b0, hs);
        tick(3);
        checks++;
        if (sel !== 1'b0) begin
            errors++;
            $display("FAIL sel_after_err got=%b exp=0", sel);
        end
        wait_drain(5);
        hb_en_b = 1'b1;
        wait_alive(2'b11);
    endtask

    task automatic test_failover();
        int hs;
        int t;
        do_req(1'b1, K_DONE, ST + 3, 1'b1, hs);
        wait_drain(ST + 10);
        hb_en_b = 1'b0;
        t = cyc;
        sb.push_back('{K_FO, t + TO - 1, t + TO + 4, 1'b1});
        wait_drain(TO + ST + 30);
        checks++;
        if (sel !== 1'b0 || alive !== 2'b01) begin
            errors++;
            $display("FAIL failover_end got sel=%b alive=%b exp sel=0 alive=01", sel, alive);
        end
        hb_en_b = 1'b1;
        wait_alive(2'b11);
    endtask

    task automatic test_both_dead_priority();
        int   hs;
        int   n;
        logic bad;
        do_req(1'b1, K_DONE, ST + 3, 1'b1, hs);
        wait_drain(ST + 10);
        hb_en_a = 1'b0;
        tick(TO + 8);
        checks++;
        if (alive !== 2'b10 || sel !== 1'b1) begin
            errors++;
            $display("FAIL a_dead got alive=%b sel=%b exp alive=10 sel=1", alive, sel);
        end
        hb_en_b = 1'b0;
        tick(TO + 8);
        checks++;
        if (alive !== 2'b00) begin
            errors++;
            $display("FAIL both_dead_alive got=%b exp=00", alive);
        end
        bad = 1'b0;
        repeat (8) begin
            if (sel !== 1'b1 || req_ready !== 1'b1) bad = 1'b1;
            tick(1);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL both_dead_hold got=changed exp sel=1 ready=1");
        end
        // A revives; a request in that very cycle must beat the failover.
        hb_en_a = 1'b1;
        n = 0;
        while (alive[0] !== 1'b1 && n < 30) begin
            tick(1);
            n++;
        end
        checks++;
        if (alive[0] !== 1'b1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL a_revive got alive=%b ready=%b exp alive[0]=1 ready=1", alive, req_ready);
        end
        req_valid = 1'b1;
        req_sel   = 1'b1;
        hs        = cyc + 1;
        sb.push_back('{K_DONE, hs + 2, hs + 2, 1'b1});
        sb.push_back('{K_FO, hs + 3, hs + 3, 1'b1});
        tick(1);
        req_valid = 1'b0;
        wait_drain(ST + 20);
        checks++;
        if (sel !== 1'b0) begin
            errors++;
            $display("FAIL priority_end_sel got=%b exp=0", sel);
        end
        hb_en_b = 1'b1;
        wait_alive(2'b11);
    endtask

    task automatic test_reset_mid_settle();
        int   hs;
        logic bad;
        do_req(1'b1, K_DONE, ST + 3, 1'b1, hs);
        tick(3);
        checks++;
        if (sel !== 1'b1) begin
            errors++;
            $display("FAIL settle_sel got=%b exp=1", sel);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({sel, req_ready, done} !== 3'b010) begin
            errors++;
            $display("FAIL async_reset got sel/ready/done=%b exp=010", {sel, req_ready, done});
        end
        sb.delete();
        tick(2);
        rst = 1'b0;
        bad = 1'b0;
        repeat (12) begin
            tick(1);
            if (sel !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL post_reset_idle got=changed exp sel=0 ready=1");
        end
    endtask

    initial begin
        test_reset();
        test_switch();
        test_same_sel();
        test_dead_target();
        test_failover();
        test_both_dead_priority();
        test_reset_mid_settle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clkswitch_ctrl.md
CLKSWITCH_CTRL -- requirements
Module: clkswitch_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: i_clk cycles without a heartbeat edge before a source is declared dead.
REQ-002 SHALL have parameter SETTLE, default 16: i_clk cycles o_sel is held stable before a switch is reported complete.
REQ-003 SHALL have port i_clk  input  1  the single always-on control clock.
REQ-004 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_hb_a  input  1  heartbeat toggle from clock A domain, toggling at that clock divided by 2^N.
REQ-006 SHALL have port i_hb_b  input  1  heartbeat toggle from clock B domain.
REQ-007 SHALL have port i_req_valid  input  1  switch request valid.
REQ-008 SHALL have port i_req_sel  input  1  requested source: 0 = A, 1 = B.
REQ-009 SHALL have port o_req_ready  output  1  request accepted when high with i_req_valid.
REQ-010 SHALL have port o_sel  output  1  select driven to the glitch-free switch: 0 = A, 1 = B.
REQ-011 SHALL have port o_done  output  1  one-cycle pulse when a switch completes.
REQ-012 SHALL have port o_err  output  1  one-cycle pulse when a request is rejected because its target is dead.
REQ-013 SHALL have port o_failover  output  1  one-cycle pulse when an automatic switch away from a dead source starts.
REQ-014 SHALL have port o_alive  output  2  per-source liveness: bit0 = A, bit1 = B.

Function
REQ-015 SHALL synchronise each heartbeat through 2 flops, then detect any edge with a third flop.
REQ-016 SHALL keep a per-source counter that clears on a heartbeat edge and saturates at TIMEOUT; alive = counter < TIMEOUT.
REQ-017 SHALL implement FSM states IDLE, CHECK, SWITCH, SETTLE, DONE.
REQ-018 SHALL drive o_req_ready high only in IDLE; a handshake latches i_req_sel as the target and moves to CHECK.
REQ-019 In CHECK, SHALL move to DONE without changing o_sel if target == o_sel; otherwise SHALL move to SWITCH if the target is alive; otherwise SHALL pulse o_err and return to IDLE.
REQ-020 In SWITCH, SHALL update o_sel to the target, load the settle counter with SETTLE-1, and move to SETTLE.
REQ-021 In SETTLE, SHALL decrement to 0 and then move to DONE; SETTLE = 1 SHALL give exactly one SETTLE cycle.
REQ-022 In DONE, SHALL pulse o_done for one cycle and return to IDLE.
REQ-023 Failover: in IDLE with no valid request, SHALL set target = ~o_sel, pulse o_failover, and enter SWITCH when the current source is dead and the other is alive.
REQ-024 If both sources are dead, SHALL stay in IDLE with o_sel unchanged.
REQ-025 A request SHALL take priority over failover in the same IDLE cycle.
REQ-026 SHALL let liveness changes during SETTLE complete the switch; failover is re-evaluated afterwards in IDLE.
REQ-027 Request-to-o_done latency for an alive, different target SHALL be SETTLE+3 cycles after the handshake cycle.

Reset
REQ-028 On i_reset, SHALL set FSM = IDLE, o_sel = 0, o_done/o_err/o_failover = 0, and the settle counter to 0.
REQ-029 On i_reset, SHALL set heartbeat counters to 0, so both sources read alive until TIMEOUT elapses; synchroniser flops SHALL reset to 0.
REQ-030 Reset asserted mid-switch SHALL return o_sel to 0 asynchronously, with no o_done pulse.

Structure
REQ-031 SHALL place the FSM state enum and source encodings (SRC_A = 0, SRC_B = 1) in a shared package clkswitch_pkg.
REQ-032 SHALL implement the synchroniser, edge detector and timeout counter as sub-module clk_alive_monitor, instantiated twice.

Verification
REQ-033 Both heartbeats toggling every 4 cycles, request sel=1 -> o_sel = 1 at SWITCH, o_done exactly SETTLE+3 cycles after the handshake.
REQ-034 Stop i_hb_b for TIMEOUT+4 cycles, then request sel=1 -> o_alive[1] = 0, o_err pulse, o_sel stays 0.
REQ-035 With o_sel = 1, stop i_hb_b while A is alive -> o_failover pulse, o_sel = 0, o_done after SETTLE+2 cycles.
REQ-036 Request sel equal to the current o_sel -> o_done without any o_sel change; both heartbeats dead -> no state change.
REQ-037 Assert i_reset during SETTLE -> o_sel = 0 immediately, FSM in IDLE, no o_done.
REQ-038 Request and failover conditions in the same cycle -> request wins.
